oled_page_writer: RTL and testbench

//  Downstream of the OLED init sequencer: after init reports done, streams a full frame from
//  an external byte-wide frame buffer to the SSD1306 over SPI.
//  For each page it sends page/column address commands (dc=0), then COLS data bytes (dc=1).

---
 rtl/oled_page_writer_pkg.sv | 31 +++
 rtl/oled_page_writer_spi_ctrl.sv | 75 +++++++
 rtl/oled_page_writer.sv | 128 ++++++++++++
 tb/tb_oled_page_writer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/oled_page_writer_pkg.sv
// Shared constants for the SSD1306 page writer: panel geometry, command bytes
// and the writer's state encoding.
package oled_pkg;

   localparam int OLED_PAGES = 4;
   localparam int OLED_COLS  = 128;

   localparam logic [7:0] OLED_CMD_PAGE  = 8'hB0;
   localparam logic [7:0] OLED_CMD_COLLO = 8'h00;
   localparam logic [7:0] OLED_CMD_COLHI = 8'h10;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_CMD   = 3'd1;
   localparam state_t ST_FETCH = 3'd2;
   localparam state_t ST_LOAD  = 3'd3;
   localparam state_t ST_SEND  = 3'd4;
   localparam state_t ST_GAP   = 3'd5;
   localparam state_t ST_DONE  = 3'd6;

   // Per-page addressing preamble: page select, then column pointer low/high nibble = 0.
   function automatic logic [7:0] cmdByte(input logic [1:0] idx, input logic [7:0] page);
      case (idx)
         2'd0:    return OLED_CMD_PAGE | page;
         2'd1:    return OLED_CMD_COLLO;
         default: return OLED_CMD_COLHI;
      endcase
   endfunction

endpackage

// File: rtl/oled_page_writer_spi_ctrl.sv
// Byte-wide SPI shifter (MSB first, SCLK idles low, data sampled on rising SCLK).
// SPI_FIN stays high after the last bit until SPI_EN is dropped, which re-arms it.
module SpiCtrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       SPI_EN,
   input  logic [7:0] SPI_DATA,
   output logic       SPI_FIN,
   output logic       SCLK,
   output logic       SDO
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0] state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_q, bit_d;
   logic       sclk_q, sclk_d;

   // Each bit takes two clocks: SDO settles while SCLK is low, then SCLK rises.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      sclk_d  = sclk_q;
      case (state_q)
         S_IDLE: begin
            if (SPI_EN) begin
               shift_d = SPI_DATA;
               bit_d   = 3'd0;
               sclk_d  = 1'b0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (!sclk_q) begin
               sclk_d = 1'b1;
            end else begin
               sclk_d = 1'b0;
               if (bit_q == 3'd7) begin
                  state_d = S_DONE;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {shift_q[6:0], 1'b0};
               end
            end
         end
         S_DONE: begin
            if (!SPI_EN) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         shift_q <= 8'h00;
         bit_q   <= 3'd0;
         sclk_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         sclk_q  <= sclk_d;
      end
   end

   assign SPI_FIN = (state_q == S_DONE);
   assign SCLK    = sclk_q;
   assign SDO     = shift_q[7];

endmodule

// File: rtl/oled_page_writer.sv
// Streams one frame from a byte-wide frame buffer to an SSD1306 once the init
// stage is finished: per page, three address commands followed by COLS data bytes.
module oled_page_writer
   import oled_pkg::*;
#(
   parameter int PAGES = OLED_PAGES,
   parameter int COLS  = OLED_COLS
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          init_fin,
   input  logic [7:0]                    mem_data,
   output logic [$clog2(PAGES*COLS)-1:0] mem_addr,
   output logic                          dc,
   output logic                          sclk,
   output logic                          sdo,
   output logic                          busy,
   output logic                          fin
);

   localparam int AW = $clog2(PAGES*COLS);
   localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

   state_t        state_q, state_d;
   logic [PW-1:0] page_q, page_d;
   logic [CW-1:0] col_q, col_d;
   logic [1:0]    cmdIdx_q, cmdIdx_d;
   logic [7:0]    tx_q, tx_d;
   logic          dc_q, dc_d;
   logic          spiEn, spiFin;

   // dc_q still describes the byte just sent while in Gap, so it selects the phase.
   always_comb begin
      state_d  = state_q;
      page_d   = page_q;
      col_d    = col_q;
      cmdIdx_d = cmdIdx_q;
      tx_d     = tx_q;
      dc_d     = dc_q;
      case (state_q)
         ST_IDLE: begin
            if (en && init_fin) begin
               page_d   = '0;
               col_d    = '0;
               cmdIdx_d = 2'd0;
               state_d  = ST_CMD;
            end
         end
         ST_CMD: begin
            tx_d    = cmdByte(cmdIdx_q, 8'(page_q));
            dc_d    = 1'b0;
            state_d = ST_SEND;
         end
         ST_FETCH: state_d = ST_LOAD;
         ST_LOAD: begin
            tx_d    = mem_data;
            dc_d    = 1'b1;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (spiFin) state_d = ST_GAP;
         end
         ST_GAP: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else if (!dc_q) begin
               if (cmdIdx_q == 2'd2) begin
                  col_d   = '0;
                  state_d = ST_FETCH;
               end else begin
                  cmdIdx_d = cmdIdx_q + 2'd1;
                  state_d  = ST_CMD;
               end
            end else if (col_q != CW'(COLS - 1)) begin
               col_d   = col_q + 1'b1;
               state_d = ST_FETCH;
            end else if (page_q != PW'(PAGES - 1)) begin
               page_d   = page_q + 1'b1;
               cmdIdx_d = 2'd0;
               state_d  = ST_CMD;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!en) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         page_q   <= '0;
         col_q    <= '0;
         cmdIdx_q <= 2'd0;
         tx_q     <= 8'h00;
         dc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         page_q   <= page_d;
         col_q    <= col_d;
         cmdIdx_q <= cmdIdx_d;
         tx_q     <= tx_d;
         dc_q     <= dc_d;
      end
   end

   assign spiEn    = (state_q == ST_SEND);
   assign mem_addr = AW'(page_q) * AW'(COLS) + AW'(col_q);
   assign dc       = dc_q;
   assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign fin      = (state_q == ST_DONE);

   SpiCtrl uSpi (
      .clk      (clk),
      .rst      (rst),
      .SPI_EN   (spiEn),
      .SPI_DATA (tx_q),
      .SPI_FIN  (spiFin),
      .SCLK     (sclk),
      .SDO      (sdo)
   );

endmodule

// File: tb/tb_oled_page_writer.sv
// Self-checking bench for oled_page_writer: decodes the SPI stream into {dc,byte}
// records and compares them against an independently generated frame.
module tb_oled_page_writer;

   localparam int PAGES = 4;
   localparam int COLS  = 128;
   localparam int AW    = 9;
   localparam int FRAME = PAGES * (3 + COLS);

   logic          clk = 1'b0;
   logic          rst, en, initFin;
   logic [7:0]    memData;
   logic [AW-1:0] memAddr;
   logic          dc, sclk, sdo, busy, fin;

   int         assertCount = 0;
   int         failCount   = 0;
   logic [8:0] expQ[$];
   logic [8:0] rxQ[$];
   int         rxTotal   = 0;
   int         edgeCount = 0;
   int         dcGlitch  = 0;
   int         bitCnt    = 0;
   logic [7:0] shiftIn   = 8'h00;
   logic       dcFirst   = 1'b0;
   logic       sclkPrev  = 1'b0;
   logic       finSeen   = 1'b0;
   logic       busySeen  = 1'b0;

   oled_page_writer #(.PAGES(PAGES), .COLS(COLS)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .init_fin (initFin),
      .mem_data (memData),
      .mem_addr (memAddr),
      .dc       (dc),
      .sclk     (sclk),
      .sdo      (sdo),
      .busy     (busy),
      .fin      (fin)
   );

   always #5 clk = ~clk;

   // Frame buffer holds addr[7:0]; one cycle read latency.
   always @(posedge clk) memData <= memAddr[7:0];

   // SPI monitor: sample on rising SCLK, seen from the falling system clock edge.
   always @(negedge clk) begin
      if (fin) finSeen = 1'b1;
      if (busy) busySeen = 1'b1;
      if (rst) begin
         bitCnt = 0;
      end else if (sclk && !sclkPrev) begin
         edgeCount++;
         if (bitCnt == 0) dcFirst = dc;
         else if (dc !== dcFirst) dcGlitch++;
         shiftIn = {shiftIn[6:0], sdo};
         bitCnt++;
         if (bitCnt == 8) begin
            rxQ.push_back({dcFirst, shiftIn});
            rxTotal++;
            bitCnt = 0;
         end
      end
      sclkPrev = sclk;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pushFrame(input int limit);
      int n = 0;
      for (int p = 0; p < PAGES; p++) begin
         for (int k = 0; k < 3 + COLS; k++) begin
            logic [8:0] e;
            if (k == 0)      e = {1'b0, 8'hB0 + 8'(p)};
            else if (k == 1) e = 9'h000;
            else if (k == 2) e = 9'h010;
            else             e = {1'b1, 8'((p * COLS + k - 3) % 256)};
            if (n < limit) expQ.push_back(e);
            n++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; initFin = 1'b0;
      repeat (3) tick();
      assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      assertCount++; if (fin !== 1'b0) begin failCount++; $display("[TB] FAIL reset_fin: got %b want 0", fin); end
      assertCount++; if (dc !== 1'b0) begin failCount++; $display("[TB] FAIL reset_dc: got %b want 0", dc); end
      assertCount++; if (sclk !== 1'b0) begin failCount++; $display("[TB] FAIL reset_sclk: got %b want 0", sclk); end
      assertCount++; if (memAddr !== '0) begin failCount++; $display("[TB] FAIL reset_addr: got %0d want 0", memAddr); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_no_init();
      int e0 = edgeCount;
      finSeen = 1'b0; busySeen = 1'b0;
      en = 1'b1; initFin = 1'b0;
      repeat (100) tick();
      assertCount++; if (edgeCount != e0) begin failCount++; $display("[TB] FAIL noinit_sclk: got %0d edges want 0", edgeCount - e0); end
      assertCount++; if (busySeen !== 1'b0) begin failCount++; $display("[TB] FAIL noinit_busy: got %b want 0", busySeen); end
      assertCount++; if (finSeen !== 1'b0) begin failCount++; $display("[TB] FAIL noinit_fin: got %b want 0", finSeen); end
   endtask

   task automatic test_full_frame();
      int cyc = 0;
      logic [8:0] got, exp;
      expQ.delete(); rxQ.delete(); dcGlitch = 0;
      pushFrame(FRAME);
      initFin = 1'b1; en = 1'b1;
      while (fin !== 1'b1 && cyc < 30000) begin tick(); cyc++; end
      assertCount++; if (fin !== 1'b1) begin failCount++; $display("[TB] FAIL frame_timeout: fin=%b after %0d cycles want 1", fin, cyc); end
      assertCount++; if (rxQ.size() != FRAME) begin failCount++; $display("[TB] FAIL frame_len: got %0d bytes want %0d", rxQ.size(), FRAME); end
      for (int i = 0; expQ.size() > 0; i++) begin
         exp = expQ.pop_front();
         assertCount++;
         if (rxQ.size() == 0) begin
            failCount++; $display("[TB] FAIL frame_byte%0d: got nothing want %h", i, exp);
            break;
         end
         got = rxQ.pop_front();
         if (got !== exp) begin failCount++; $display("[TB] FAIL frame_byte%0d: got dc/byte %h want %h", i, got, exp); end
      end
      assertCount++; if (dcGlitch != 0) begin failCount++; $display("[TB] FAIL frame_dc_stable: got %0d changes want 0", dcGlitch); end
      assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL frame_busy: got %b want 0", busy); end
   endtask

   task automatic test_done_hold();
      int e0 = edgeCount;
      int finLow = 0;
      repeat (50) begin tick(); if (fin !== 1'b1) finLow++; end
      assertCount++; if (finLow != 0) begin failCount++; $display("[TB] FAIL done_fin_hold: got %0d low cycles want 0", finLow); end
      assertCount++; if (edgeCount != e0) begin failCount++; $display("[TB] FAIL done_quiet: got %0d edges want 0", edgeCount - e0); end
      assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL done_busy: got %b want 0", busy); end
      en = 1'b0;
      tick();
      assertCount++; if (fin !== 1'b0) begin failCount++; $display("[TB] FAIL done_fin_drop: got %b want 0", fin); end
      assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL done_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_en_drop();
      int base = rxTotal;
      int cyc = 0;
      logic [8:0] got, exp;
      expQ.delete(); rxQ.delete(); finSeen = 1'b0;
      pushFrame(185);
      en = 1'b1; initFin = 1'b1;
      while (rxTotal - base < 20 && cyc < 20000) begin tick(); cyc++; end
      initFin = 1'b0;
      while (!(rxTotal - base == 184 && bitCnt >= 1) && cyc < 20000) begin tick(); cyc++; end
      assertCount++; if (cyc >= 20000) begin failCount++; $display("[TB] FAIL endrop_timeout: got %0d bytes want 184", rxTotal - base); end
      en = 1'b0;
      repeat (200) tick();
      assertCount++; if (rxTotal - base != 185) begin failCount++; $display("[TB] FAIL endrop_count: got %0d bytes want 185", rxTotal - base); end
      assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL endrop_busy: got %b want 0", busy); end
      assertCount++; if (finSeen !== 1'b0) begin failCount++; $display("[TB] FAIL endrop_fin: got %b want 0", finSeen); end
      for (int i = 0; expQ.size() > 0 && rxQ.size() > 0; i++) begin
         exp = expQ.pop_front();
         got = rxQ.pop_front();
         assertCount++;
         if (got !== exp) begin failCount++; $display("[TB] FAIL endrop_byte%0d: got %h want %h", i, got, exp); end
      end
      initFin = 1'b1;
   endtask

   task automatic test_reset_mid_byte();
      int base = rxTotal;
      int cyc = 0;
      logic [8:0] got, exp;
      expQ.delete(); rxQ.delete();
      en = 1'b1; initFin = 1'b1;
      while (!(rxTotal - base == 10 && bitCnt >= 2) && cyc < 20000) begin tick(); cyc++; end
      rst = 1'b1;
      #1;
      assertCount++; if (dc !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_dc: got %b want 0", dc); end
      assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
      assertCount++; if (sclk !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_sclk: got %b want 0", sclk); end
      tick();
      assertCount++; if (sclk !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_sclk_idle: got %b want 0", sclk); end
      rst = 1'b0;
      rxQ.delete();
      pushFrame(3);
      cyc = 0;
      while (rxQ.size() < 3 && cyc < 2000) begin tick(); cyc++; end
      en = 1'b0;
      assertCount++; if (rxQ.size() < 3) begin failCount++; $display("[TB] FAIL midrst_restart: got %0d bytes want 3", rxQ.size()); end
      for (int i = 0; expQ.size() > 0 && rxQ.size() > 0; i++) begin
         exp = expQ.pop_front();
         got = rxQ.pop_front();
         assertCount++;
         if (got !== exp) begin failCount++; $display("[TB] FAIL midrst_byte%0d: got %h want %h", i, got, exp); end
      end
      cyc = 0;
      while (busy !== 1'b0 && cyc < 200) begin tick(); cyc++; end
      assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_stop: busy=%b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_no_init();
      test_full_frame();
      test_done_hold();
      test_en_drop();
      test_reset_mid_byte();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
